bla_sub_4bits: RTL and testbench



---
 rtl/bla_sub_4bits.sv | 139 +++++++++++++
 tb/tb_bla_sub_4bits.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bla_sub_4bits.sv
// Sequential 4-bit borrow-lookahead subtractor: one A - B - Bin per button press,
// computed through a registered generate/propagate stage and a flat lookahead stage.
module bla_sub_4bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Bin,
  output logic [4:0] Q,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StGp, StLook, StHold} state_e;

  state_e     state_q, state_d;
  logic       en_meta_q, en_meta_d;
  logic       en_s_q, en_s_d;
  logic       en_d_q, en_d_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       bin_q, bin_d;
  logic [3:0] g_q, g_d;
  logic [3:0] p_q, p_d;
  logic [4:0] q_q, q_d;
  logic       valid_q, valid_d;

  logic       rise;
  logic       settled;
  logic [4:0] brw;
  logic [3:0] diff;

  assign rise    = en_s_q & ~en_d_q;
  assign settled = (settle_q == 2'd3);

  // Flat borrow lookahead; brw[0] is the registered borrow-in.
  always_comb begin
    brw[0] = bin_q;
    brw[1] = g_q[0] | (p_q[0] & bin_q);
    brw[2] = g_q[1] | (p_q[1] & g_q[0]) | (p_q[1] & p_q[0] & bin_q);
    brw[3] = g_q[2] | (p_q[2] & g_q[1]) | (p_q[2] & p_q[1] & g_q[0])
           | (p_q[2] & p_q[1] & p_q[0] & bin_q);
    brw[4] = g_q[3] | (p_q[3] & g_q[2]) | (p_q[3] & p_q[2] & g_q[1])
           | (p_q[3] & p_q[2] & p_q[1] & g_q[0])
           | (p_q[3] & p_q[2] & p_q[1] & p_q[0] & bin_q);
    // a ^ b is the complement of the propagate term
    diff   = ~p_q ^ brw[3:0];
  end

  always_comb begin
    state_d   = state_q;
    en_meta_d = enable;
    en_s_d    = en_meta_q;
    en_d_d    = en_s_q;
    settle_d  = settled ? settle_q : settle_q + 2'd1;
    armed_d   = armed_q;
    a_d       = a_q;
    b_d       = b_q;
    bin_d     = bin_q;
    g_d       = g_q;
    p_d       = p_q;
    q_d       = q_q;
    valid_d   = 1'b0;

    // A press is only accepted once IDLE has seen the button released, which also
    // blocks a spurious rise when reset lifts with the button already held.
    if (settled && (state_q == StIdle) && !en_s_q) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rise && armed_q) begin
          a_d     = A;
          b_d     = B;
          bin_d   = Bin;
          armed_d = 1'b0;
          state_d = StGp;
        end
      end
      StGp: begin
        g_d     = ~a_q & b_q;
        p_d     = ~(a_q ^ b_q);
        state_d = StLook;
      end
      StLook: begin
        q_d     = {brw[4], diff};
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (!en_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
      en_d_q    <= 1'b0;
      settle_q  <= 2'd0;
      armed_q   <= 1'b0;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      bin_q     <= 1'b0;
      g_q       <= 4'd0;
      p_q       <= 4'd0;
      q_q       <= 5'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_meta_q <= en_meta_d;
      en_s_q    <= en_s_d;
      en_d_q    <= en_d_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      a_q       <= a_d;
      b_q       <= b_d;
      bin_q     <= bin_d;
      g_q       <= g_d;
      p_q       <= p_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
    end
  end

  assign Q     = q_q;
  assign valid = valid_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_bla_sub_4bits.sv
// Directed bench for bla_sub_4bits: press timing, arithmetic vectors, exhaustive sweep,
// held/re-pressed button, operand isolation and reset during an operation.
module tb_bla_sub_4bits;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic [4:0] Q;
  logic       valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  bla_sub_4bits dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .A      (A),
    .B      (B),
    .Bin    (Bin),
    .Q      (Q),
    .valid  (valid),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid === 1'b1) vcount++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press, wait for valid (bounded), check latency and Q, release, wait for IDLE.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic bi, input logic [4:0] exp);
    int edges;
    bit found;
    A = a;
    B = b;
    Bin = bi;
    enable = 1'b1;
    edges = 0;
    found = 1'b0;
    while (!found && edges < 12) begin
      tick(1);
      edges++;
      if (valid === 1'b1) found = 1'b1;
    end
    check({tag, "_latency"}, edges, 5);
    check({tag, "_q"}, Q, exp);
    enable = 1'b0;
    edges = 0;
    while (busy !== 1'b0 && edges < 12) begin
      tick(1);
      edges++;
    end
    check({tag, "_idle"}, busy, 1'b0);
    tick(4);
  endtask

  initial begin
    int v0;
    int edges;
    logic [4:0] exp;

    rst_n = 1'b0;
    enable = 1'b0;
    A = 4'd0;
    B = 4'd0;
    Bin = 1'b0;
    tick(3);
    check("reset_q", Q, 5'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(8);

    // Basic borrow with edge-by-edge timing
    A = 4'd5;
    B = 4'd7;
    Bin = 1'b0;
    enable = 1'b1;
    tick(2);
    check("e2_busy", busy, 1'b0);
    tick(1);
    check("e3_busy", busy, 1'b1);
    check("e3_valid", valid, 1'b0);
    tick(1);
    check("e4_valid", valid, 1'b0);
    tick(1);
    check("e5_valid", valid, 1'b1);
    check("e5_q", Q, 5'h1E);
    enable = 1'b0;
    tick(1);
    check("e6_valid", valid, 1'b0);
    check("e6_q_hold", Q, 5'h1E);
    tick(6);

    do_op("no_borrow", 4'd8, 4'd7, 1'b0, 5'h01);
    do_op("borrow_in", 4'd9, 4'd4, 1'b1, 5'h04);
    do_op("wrap", 4'd0, 4'd0, 1'b1, 5'h1F);
    do_op("equal", 4'd15, 4'd15, 1'b0, 5'h00);

    // Exhaustive sweep against a 5-bit reference
    v0 = vcount;
    for (int i = 0; i < 512; i++) begin
      int ai;
      int bb;
      int ci;
      ai = (i >> 5) & 15;
      bb = (i >> 1) & 15;
      ci = i & 1;
      exp[4] = (ai < bb + ci);
      exp[3:0] = 4'((ai - bb - ci) & 15);
      do_op("sweep", 4'(ai), 4'(bb), 1'(ci), exp);
    end
    check("sweep_valid_count", vcount - v0, 512);

    // Held button: one valid, busy drops on the third edge after release
    v0 = vcount;
    A = 4'd3;
    B = 4'd1;
    Bin = 1'b0;
    enable = 1'b1;
    tick(50);
    check("held_one_valid", vcount - v0, 1);
    check("held_q", Q, 5'h02);
    check("held_busy", busy, 1'b1);
    enable = 1'b0;
    tick(1);
    check("rel_e1_busy", busy, 1'b1);
    tick(1);
    check("rel_e2_busy", busy, 1'b1);
    tick(1);
    check("rel_e3_busy", busy, 1'b0);
    tick(4);

    // Release and re-press while busy: ignored
    v0 = vcount;
    A = 4'd6;
    B = 4'd2;
    enable = 1'b1;
    tick(3);
    check("repress_busy", busy, 1'b1);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(20);
    check("repress_idle", busy, 1'b0);
    enable = 1'b0;
    tick(6);
    check("repress_one_valid", vcount - v0, 1);
    check("repress_q", Q, 5'h04);
    do_op("after_repress", 4'd7, 4'd9, 1'b1, 5'h1D);

    // Operand change after capture does not disturb the result
    A = 4'd12;
    B = 4'd3;
    Bin = 1'b0;
    enable = 1'b1;
    tick(3);
    A = 4'd0;
    B = 4'd15;
    Bin = 1'b1;
    edges = 3;
    while (valid !== 1'b1 && edges < 12) begin
      tick(1);
      edges++;
    end
    check("opchg_latency", edges, 5);
    check("opchg_q", Q, 5'h09);
    enable = 1'b0;
    tick(8);

    // Reset mid-operation with enable held through reset release
    A = 4'd10;
    B = 4'd2;
    Bin = 1'b0;
    enable = 1'b1;
    tick(3);
    check("rst_pre_busy", busy, 1'b1);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("rst_q", Q, 5'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    v0 = vcount;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(15);
    check("rst_held_busy", busy, 1'b0);
    check("rst_held_no_valid", vcount - v0, 0);
    check("rst_held_q", Q, 5'h00);
    enable = 1'b0;
    tick(6);
    do_op("after_reset", 4'd10, 4'd2, 1'b0, 5'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
